counter_sequencer: RTL and testbench

- Controller that shares one dekatron-style BCD Counter (Request/Ready handshake, Dec, Set, In, Out) between two requesters (port A, port B).
- Accepts multi-step commands (INC by N, DEC by N, SET value) and turns each into a sequence of single-step Counter handshakes.
- Round-robin arbitration between the ports; per-step watchdog.
- Sits between the sequencing logic (IP/AP control) and the Counter datapath.

---
 rtl/counter_sequencer_pkg.sv | 24 ++
 rtl/counter_sequencer_arb.sv | 34 +++
 rtl/counter_sequencer.sv | 157 +++++++++++++++
 tb/tb_counter_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared types for the counter sequencer.
// Opcodes, FSM states, port ids, default digit count.
package counter_sequencer_pkg;

  localparam int D_NUM_DEF = 6;

  localparam logic [1:0] OP_INC = 2'd0;
  localparam logic [1:0] OP_DEC = 2'd1;
  localparam logic [1:0] OP_SET = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_RDY,
    S_DONE
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/counter_sequencer_arb.sv
// 2-way round-robin arbiter: Clk/Rst, req[1:0] (A=bit0), upd = grant taken.
// gnt[1:0] one-hot; the port not granted last wins a tie.
module rr_arbiter2
  import counter_sequencer_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  port_t ptr;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr == PORT_B) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer names the port that wins the next tie.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr <= PORT_A;
    end else if (upd) begin
      ptr <= gnt[0] ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Shares one BCD counter between ports A/B; splits INC/DEC/SET into steps.
// Ports: A*/B* command ports, Result/Err/Busy status, Cnt* counter link.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int D_NUM   = D_NUM_DEF,
  parameter int STEP_W  = 4,
  parameter int TIMEOUT = 255
)(
  input  logic                Clk,
  input  logic                Rst,
  input  logic                AReq,
  input  logic [1:0]          AOp,
  input  logic [STEP_W-1:0]   ASteps,
  input  logic [D_NUM*4-1:0]  AData,
  output logic                AAck,
  input  logic                BReq,
  input  logic [1:0]          BOp,
  input  logic [STEP_W-1:0]   BSteps,
  input  logic [D_NUM*4-1:0]  BData,
  output logic                BAck,
  output logic [D_NUM*4-1:0]  Result,
  output logic                Err,
  output logic                Busy,
  output logic                CntRequest,
  output logic                CntDec,
  output logic                CntSet,
  output logic [D_NUM*4-1:0]  CntIn,
  input  logic                CntReady,
  input  logic [D_NUM*4-1:0]  CntOut
);

  localparam int DW   = D_NUM * 4;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t state, state_nx;

  logic [1:0]        gnt;
  port_t             sel_port;
  logic [1:0]        sel_op;
  logic [STEP_W-1:0] sel_steps;
  logic [DW-1:0]     sel_data;
  logic              sel_zero;
  logic              grant;

  port_t             own_q;
  logic [1:0]        op_q;
  logic [STEP_W-1:0] rem_q;
  logic [DW-1:0]     data_q;
  logic [WD_W-1:0]   wd_q;
  logic              err_q;

  rr_arbiter2 u_arb (
    .Clk (Clk),
    .Rst (Rst),
    .req ({BReq, AReq}),
    .upd (grant),
    .gnt (gnt)
  );

  assign sel_port  = gnt[1] ? PORT_B : PORT_A;
  assign sel_op    = gnt[1] ? BOp    : AOp;
  assign sel_steps = gnt[1] ? BSteps : ASteps;
  assign sel_data  = gnt[1] ? BData  : AData;

  // Zero-step INC/DEC never touches the counter, so it needs no Ready.
  assign sel_zero = (sel_op != OP_SET) && (sel_steps == '0);
  assign grant = (state == S_IDLE) && (|gnt) && (sel_zero || CntReady);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (grant) begin
          state_nx = sel_zero ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE:     state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY: state_nx = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (CntReady) begin
          state_nx = (rem_q == STEP_W'(1)) ? S_DONE : S_ISSUE;
        end else if (wd_q == WD_LAST) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      own_q  <= PORT_A;
      op_q   <= OP_INC;
      rem_q  <= '0;
      data_q <= '0;
      wd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant) begin
        own_q  <= sel_port;
        op_q   <= sel_op;
        rem_q  <= (sel_op == OP_SET) ? STEP_W'(1) : sel_steps;
        data_q <= sel_data;
        err_q  <= 1'b0;
      end
      if (state == S_WAIT_BUSY) begin
        wd_q <= '0;
      end
      if (state == S_WAIT_RDY) begin
        if (CntReady) begin
          rem_q <= rem_q - STEP_W'(1);
        end else if (wd_q == WD_LAST) begin
          err_q <= 1'b1;
        end else begin
          wd_q <= wd_q + WD_W'(1);
        end
      end
    end
  end

  always_comb begin
    Busy       = (state != S_IDLE);
    CntDec     = Busy && (op_q == OP_DEC);
    CntRequest = 1'b0;
    CntSet     = 1'b0;
    CntIn      = '0;
    AAck       = 1'b0;
    BAck       = 1'b0;
    Result     = '0;
    Err        = 1'b0;
    if (state == S_ISSUE) begin
      CntRequest = 1'b1;
      if (op_q == OP_SET) begin
        CntSet = 1'b1;
        CntIn  = data_q;
      end
    end
    if (state == S_DONE) begin
      AAck   = (own_q == PORT_A);
      BAck   = (own_q == PORT_B);
      Result = CntOut;
      Err    = err_q;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural BCD counter.
// Table of commands plus timeout, reset and arbitration sequences.
module tb_counter_sequencer;

  localparam int SW  = 4;
  localparam int TO  = 255;
  localparam int DLY = 3;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        AReq = 1'b0, BReq = 1'b0;
  logic [1:0]  AOp = '0, BOp = '0;
  logic [SW-1:0] ASteps = '0, BSteps = '0;
  logic [23:0] AData = '0, BData = '0;
  logic        AAck, BAck, Err, Busy;
  logic        CntRequest, CntDec, CntSet, CntReady;
  logic [23:0] Result, CntIn, CntOut;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  counter_sequencer #(
    .D_NUM(6), .STEP_W(SW), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .AReq(AReq), .AOp(AOp), .ASteps(ASteps), .AData(AData), .AAck(AAck),
    .BReq(BReq), .BOp(BOp), .BSteps(BSteps), .BData(BData), .BAck(BAck),
    .Result(Result), .Err(Err), .Busy(Busy),
    .CntRequest(CntRequest), .CntDec(CntDec), .CntSet(CntSet),
    .CntIn(CntIn), .CntReady(CntReady), .CntOut(CntOut)
  );

  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    for (int i = 0; i < 6; i++) begin
      if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
      else begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
        break;
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    for (int i = 0; i < 6; i++) begin
      if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
      else begin
        r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
        break;
      end
    end
    return r;
  endfunction

  // Behavioural counter: Ready drops after a request, returns DLY cycles later.
  logic [23:0] cnt_val = '0;
  logic        cnt_rdy = 1'b1;
  int          busy_cnt = 0;
  logic        p_set = 1'b0, p_dec = 1'b0;
  logic [23:0] p_in = '0;
  bit          stuck = 1'b0;

  always @(posedge Clk) begin
    if (CntRequest && cnt_rdy) begin
      cnt_rdy  <= 1'b0;
      busy_cnt <= DLY;
      p_set    <= CntSet;
      p_dec    <= CntDec;
      p_in     <= CntIn;
    end else if (!cnt_rdy && !stuck) begin
      if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
      else begin
        cnt_rdy <= 1'b1;
        cnt_val <= p_set ? p_in : (p_dec ? bcd_dec(cnt_val) : bcd_inc(cnt_val));
      end
    end
  end

  assign CntReady = cnt_rdy;
  assign CntOut   = cnt_val;

  int   cyc = 0;
  int   n_req = 0, n_set = 0, n_aack = 0, n_back = 0, n_decc = 0, n_flip = 0;
  int   last_req_cyc = 0;
  logic [23:0] last_in = '0;
  logic pb = 1'b0, pd = 1'b0;
  int   ack_q[$];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (CntRequest) begin n_req++; last_req_cyc = cyc; end
    if (CntSet) begin n_set++; last_in = CntIn; end
    if (AAck) begin n_aack++; ack_q.push_back(0); end
    if (BAck) begin n_back++; ack_q.push_back(1); end
    if (CntDec) n_decc++;
    if (Busy && pb && (CntDec !== pd)) n_flip++;
    pb = Busy;
    pd = CntDec;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic run_cmd(input bit port, input logic [1:0] op,
                         input logic [SW-1:0] st, input logic [23:0] d,
                         output logic [23:0] res, output logic er,
                         output int lat, output int ack_c, output bit tmo);
    tmo = 1'b1; lat = 0; res = '0; er = 1'b0; ack_c = 0;
    if (port) begin BReq = 1; BOp = op; BSteps = st; BData = d; end
    else      begin AReq = 1; AOp = op; ASteps = st; AData = d; end
    for (int k = 1; k <= 2000; k++) begin
      tick();
      if (AAck || BAck) begin
        res = Result; er = Err; lat = k; ack_c = cyc; tmo = 1'b0;
        break;
      end
    end
    AReq = 0;
    BReq = 0;
  endtask

  typedef struct {
    bit          port;
    logic [1:0]  op;
    logic [3:0]  st;
    logic [23:0] d;
    logic [23:0] res;
    int          reqs;
    int          sets;
  } vec_t;

  vec_t v[9];

  initial begin
    logic [23:0] res;
    logic er;
    int lat, ack_c, r, s, a, b, dc, fl, q0;
    bit tmo, done;

    v[0] = '{1'b0, 2'd0, 4'd5,  24'h0,      24'h000005, 5,  0};
    v[1] = '{1'b1, 2'd2, 4'd0,  24'h000039, 24'h000039, 1,  1};
    v[2] = '{1'b1, 2'd1, 4'd15, 24'h0,      24'h000024, 15, 0};
    v[3] = '{1'b0, 2'd0, 4'd0,  24'h0,      24'h000024, 0,  0};
    v[4] = '{1'b0, 2'd3, 4'd2,  24'h0,      24'h000026, 2,  0};
    v[5] = '{1'b1, 2'd2, 4'd7,  24'h999999, 24'h999999, 1,  1};
    v[6] = '{1'b0, 2'd0, 4'd1,  24'h0,      24'h000000, 1,  0};
    v[7] = '{1'b1, 2'd1, 4'd1,  24'h0,      24'h999999, 1,  0};
    v[8] = '{1'b1, 2'd1, 4'd0,  24'h0,      24'h999999, 0,  0};

    repeat (3) tick();
    chk("rst_ctl", {Busy, AAck, BAck, Err, CntRequest, CntSet, CntDec}, 0);
    chk("rst_result", Result, 0);
    chk("rst_cntin", CntIn, 0);
    Rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      r = n_req; s = n_set; a = n_aack; b = n_back; dc = n_decc; fl = n_flip;
      run_cmd(v[i].port, v[i].op, v[i].st, v[i].d, res, er, lat, ack_c, tmo);
      tick();
      chk($sformatf("v%0d_ackwait", i), tmo, 0);
      chk($sformatf("v%0d_result", i), res, v[i].res);
      chk($sformatf("v%0d_err", i), er, 0);
      chk($sformatf("v%0d_reqs", i), n_req - r, v[i].reqs);
      chk($sformatf("v%0d_sets", i), n_set - s, v[i].sets);
      if (v[i].sets != 0) chk($sformatf("v%0d_cntin", i), last_in, v[i].d);
      chk($sformatf("v%0d_aack", i), n_aack - a, v[i].port ? 0 : 1);
      chk($sformatf("v%0d_back", i), n_back - b, v[i].port ? 1 : 0);
      chk($sformatf("v%0d_dec", i), (n_decc != dc), (v[i].op == 2'd1));
      chk($sformatf("v%0d_decflip", i), n_flip - fl, 0);
      if (v[i].st == 0 && v[i].op != 2'd2) chk($sformatf("v%0d_lat", i), lat, 1);
    end

    // Counter never returns Ready: watchdog abort.
    stuck = 1'b1;
    r = n_req;
    run_cmd(1'b0, 2'd0, 4'd1, 24'h0, res, er, lat, ack_c, tmo);
    tick();
    chk("to_ackwait", tmo, 0);
    chk("to_err", er, 1);
    chk("to_lat", ack_c - last_req_cyc, TO + 2);
    chk("to_reqs", n_req - r, 1);
    chk("to_result", res, 24'h999999);
    chk("to_idle", Busy, 0);
    stuck = 1'b0;
    repeat (6) tick();

    // Reset in the middle of a 9-step command.
    run_cmd(1'b1, 2'd2, 4'd0, 24'h0, res, er, lat, ack_c, tmo);
    tick();
    chk("pre_rst_set", res, 0);
    r = n_req; a = n_aack;
    AReq = 1; AOp = 2'd0; ASteps = 4'd9;
    for (int k = 0; k < 200 && (n_req - r) < 3; k++) tick();
    chk("mid_reach", (n_req - r), 3);
    tick();
    tick();
    chk("mid_busy", Busy, 1);
    Rst = 1'b1;
    AReq = 0;
    tick();
    chk("mid_ctl", {Busy, AAck, BAck, Err, CntRequest, CntSet, CntDec}, 0);
    chk("mid_result", Result, 0);
    chk("mid_cntin", CntIn, 0);
    Rst = 1'b0;
    repeat (10) tick();
    chk("mid_noack", n_aack - a, 0);

    // Both ports requesting continuously: A first after reset, then alternate.
    q0 = ack_q.size();
    done = 1'b0;
    AReq = 1; AOp = 2'd0; ASteps = 4'd1;
    BReq = 1; BOp = 2'd0; BSteps = 4'd1;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (ack_q.size() - q0 >= 4) begin done = 1'b1; break; end
    end
    AReq = 0;
    BReq = 0;
    tick();
    chk("alt_done", done, 1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("alt_order%0d", j),
          (q0 + j < ack_q.size()) ? ack_q[q0 + j] : 2, j % 2);
    end
    repeat (4) tick();

    // Fresh commands after the reset.
    run_cmd(1'b0, 2'd2, 4'd0, 24'h000100, res, er, lat, ack_c, tmo);
    tick();
    chk("fresh_set", res, 24'h000100);
    run_cmd(1'b1, 2'd0, 4'd2, 24'h0, res, er, lat, ack_c, tmo);
    tick();
    chk("fresh_inc", res, 24'h000102);
    chk("fresh_err", er, 0);
    chk("fresh_ackwait", tmo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
